// File: rtl/linear_interpolator.sv
// Linear interpolator: rebuilds a full-rate signed 16-bit stream from a decimated,
// strobed input by ramping between successive samples in 2^L equal steps.
// The accumulator holds value * 2^M so fractional steps add up exactly.
module linear_interpolator #(
  parameter int unsigned GMaxLog = 10
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic signed [15:0] din_i,
  input  logic               din_valid_i,
  input  logic        [3:0]  interp_log_i,
  input  logic               clear_flags_i,
  output logic signed [15:0] dout_o,
  output logic               dout_valid_o,
  output logic               underrun_o,
  output logic               early_o
);

  localparam int unsigned M  = GMaxLog;
  localparam int unsigned AW = 16 + M;
  localparam int unsigned CW = M + 1;

  typedef enum logic [1:0] {StIdle, StPrime, StRun, StHold} state_e;

  state_e               state_q, state_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic signed [AW-1:0] step_q, step_d;
  logic        [CW-1:0] cnt_q, cnt_d;
  logic        [3:0]    l_q, l_d;
  logic signed [15:0]   target_q, target_d;
  logic signed [15:0]   dout_q;
  logic                 underrun_q, underrun_d;
  logic                 early_q, early_d;

  logic        [3:0]    l_clamp;
  logic        [3:0]    shamt;
  logic                 cnt_last;
  logic signed [AW-1:0] acc_adv;
  logic signed [AW-1:0] start_p;
  logic signed [15:0]   start_int;
  logic signed [16:0]   diff;
  logic signed [AW-1:0] step_new;
  logic                 start;

  // Requested ratio clamped to the widest ramp the accumulator fraction supports.
  assign l_clamp  = ({28'd0, interp_log_i} > M) ? 4'(M) : interp_log_i;
  assign shamt    = 4'(M) - l_clamp;
  assign cnt_last = (cnt_q == ((CW'(1) << l_q) - CW'(1)));

  // Step is kept modulo 2^AW: its scaled value can exceed AW bits, but the
  // accumulator sum always lands between the two endpoints, so the wrap cancels.
  assign acc_adv  = acc_q + step_q;

  // New ramp starts where the accumulator would have been this cycle anyway, so a
  // strobe mid-ramp or on the final step leaves no jump on the output.
  assign start_p   = (state_q == StRun) ? acc_adv : acc_q;
  assign start_int = start_p[AW-1:M];
  assign diff      = {din_i[15], din_i} - {start_int[15], start_int};
  assign step_new  = {{(M - 1){diff[16]}}, diff} << shamt;

  // Next-state, ramp arithmetic and sticky flag updates.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    step_d     = step_q;
    cnt_d      = cnt_q;
    l_d        = l_q;
    target_d   = target_q;
    underrun_d = underrun_q & ~clear_flags_i;
    early_d    = early_q & ~clear_flags_i;
    start      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (din_valid_i) begin
          acc_d    = {din_i, {M{1'b0}}};
          target_d = din_i;
          state_d  = StPrime;
        end
      end
      StPrime: begin
        start = din_valid_i;
      end
      StRun: begin
        if (din_valid_i) begin
          start = 1'b1;
          if (!cnt_last) begin
            early_d = 1'b1;
          end
        end else if (cnt_last) begin
          // Snap to the exact target; a mid-ramp restart may leave fraction bits.
          acc_d   = {target_q, {M{1'b0}}};
          state_d = StHold;
        end else begin
          acc_d = acc_adv;
          cnt_d = cnt_q + CW'(1);
        end
      end
      StHold: begin
        if (din_valid_i) begin
          start = 1'b1;
        end else begin
          underrun_d = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (start) begin
      acc_d    = start_p;
      step_d   = step_new;
      cnt_d    = '0;
      l_d      = l_clamp;
      target_d = din_i;
      state_d  = StRun;
    end
  end

  // State and datapath registers; output is the registered integer part of acc.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= StIdle;
      acc_q      <= '0;
      step_q     <= '0;
      cnt_q      <= '0;
      l_q        <= '0;
      target_q   <= '0;
      dout_q     <= '0;
      underrun_q <= 1'b0;
      early_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      step_q     <= step_d;
      cnt_q      <= cnt_d;
      l_q        <= l_d;
      target_q   <= target_d;
      dout_q     <= acc_q[AW-1:M];
      underrun_q <= underrun_d;
      early_q    <= early_d;
    end
  end

  assign dout_o       = dout_q;
  assign dout_valid_o = (state_q == StRun) || (state_q == StHold);
  assign underrun_o   = underrun_q;
  assign early_o      = early_q;

endmodule

// File: tb/tb_linear_interpolator.sv
// Directed bench for linear_interpolator; expected values worked out by hand.
module tb_linear_interpolator;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic signed [15:0] din = '0;
  logic               din_valid = 1'b0;
  logic        [3:0]  interp_log = '0;
  logic               clear_flags = 1'b0;
  logic signed [15:0] dout;
  logic               dout_valid;
  logic               underrun;
  logic               early;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  linear_interpolator dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .din_i         (din),
    .din_valid_i   (din_valid),
    .interp_log_i  (interp_log),
    .clear_flags_i (clear_flags),
    .dout_o        (dout),
    .dout_valid_o  (dout_valid),
    .underrun_o    (underrun),
    .early_o       (early)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one input cycle, then sample outputs 1 time unit after the edge.
  task automatic apply(input logic v, input logic signed [15:0] d);
    din       = d;
    din_valid = v;
    tick();
    din_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  int exp3 [5] = '{500, 375, 250, 125, 0};
  int j;
  int e;
  int prev;
  int bad;

  initial begin
    // 1: basic 4x ramp, hold, underrun, clear_flags vs. set priority
    do_reset();
    check("rst_dout", dout, 0);
    check("rst_valid", dout_valid, 0);
    check("rst_underrun", underrun, 0);
    check("rst_early", early, 0);
    interp_log = 4'd2;
    apply(1'b1, 16'sd0);
    check("prime_valid", dout_valid, 0);
    repeat (3) apply(1'b0, 16'sd0);
    apply(1'b1, 16'sd400);
    check("t1_valid", dout_valid, 1);
    for (int i = 0; i < 5; i++) begin
      if (i == 3) check("t1_no_underrun", underrun, 0);
      apply(1'b0, 16'sd0);
      check("t1_ramp", dout, 100 * i);
    end
    check("t1_underrun", underrun, 1);
    clear_flags = 1'b1;
    apply(1'b0, 16'sd0);
    check("t1_set_beats_clear", underrun, 1);
    apply(1'b1, 16'sd400);
    clear_flags = 1'b0;
    check("t1_clear", underrun, 0);

    // 2: 8x ramps -800 -> 800 -> -800 with on-time strobes
    do_reset();
    interp_log = 4'd3;
    apply(1'b1, -16'sd800);
    repeat (7) apply(1'b0, 16'sd0);
    apply(1'b1, 16'sd800);
    check("t2_start", dout, -800);
    for (int k = 1; k <= 17; k++) begin
      if (k == 16) begin
        check("t2_underrun", underrun, 0);
        check("t2_early", early, 0);
      end
      apply(k == 8, -16'sd800);
      j = 8 + k;
      e = (j <= 17) ? (-800 + 200 * (j - 9)) : (800 - 200 * (j - 17));
      check("t2_ramp", dout, e);
    end

    // 3: early strobe mid-ramp, continuous turn-around
    do_reset();
    interp_log = 4'd2;
    apply(1'b1, 16'sd0);
    repeat (3) apply(1'b0, 16'sd0);
    apply(1'b1, 16'sd1000);
    apply(1'b0, 16'sd0);
    check("t3_b5", dout, 0);
    apply(1'b1, 16'sd0);
    check("t3_b6", dout, 250);
    check("t3_early", early, 1);
    for (int i = 0; i < 5; i++) begin
      apply(1'b0, 16'sd0);
      check("t3_ramp", dout, exp3[i]);
    end

    // 4: L=0 zero-order hold, 2-clock latency
    do_reset();
    interp_log = 4'd0;
    apply(1'b1, 16'sd1234);
    apply(1'b1, -16'sd5000);
    check("t4_c1", dout, 1234);
    apply(1'b1, 16'sd77);
    check("t4_c2", dout, 1234);
    apply(1'b0, 16'sd0);
    check("t4_c3", dout, -5000);
    check("t4_early", early, 0);
    apply(1'b0, 16'sd0);
    check("t4_c4", dout, 77);

    // 5: clamped L=10, full-scale ramp
    do_reset();
    interp_log = 4'd15;
    apply(1'b1, -16'sd32768);
    apply(1'b1, 16'sd32767);
    prev = -32768;
    bad  = 0;
    for (int n = 1; n <= 1025; n++) begin
      apply(1'b0, 16'sd0);
      if (n == 1)    check("t5_first", dout, -32768);
      if (n == 513)  check("t5_mid", dout, -1);
      if (n == 1024) check("t5_last_step", dout, 32703);
      if (n == 1025) check("t5_end", dout, 32767);
      if (int'(dout) < prev) bad++;
      prev = int'(dout);
    end
    check("t5_monotone", bad, 0);

    // 6: reset mid-ramp, simultaneous strobe dropped
    do_reset();
    interp_log = 4'd2;
    apply(1'b1, 16'sd0);
    apply(1'b1, 16'sd400);
    apply(1'b1, 16'sd800);
    check("t6_early", early, 1);
    reset = 1'b1;
    apply(1'b1, 16'sd555);
    reset = 1'b0;
    check("t6_dout", dout, 0);
    check("t6_valid", dout_valid, 0);
    check("t6_early_rst", early, 0);
    check("t6_underrun_rst", underrun, 0);
    apply(1'b0, 16'sd0);
    apply(1'b0, 16'sd0);
    check("t6_dropped", dout, 0);
    check("t6_idle_valid", dout_valid, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
